// File: rtl/cbus_rr_arbiter_pkg.sv
// Shared CBus types used by the cache layer and the round-robin arbiter.
//   cbus_req_t  : valid, is_write, size, addr, strobe, data, len
//   cbus_resp_t : ready, last, data
// Burst length is encoded as (beats - 1), so LEN4 == 3.
package cbus_rr_arbiter_pkg;

  typedef enum logic [2:0] {
    SIZE1 = 3'd0,
    SIZE2 = 3'd1,
    SIZE4 = 3'd2,
    SIZE8 = 3'd3
  } cbus_size_t;

  typedef enum logic [3:0] {
    LEN1  = 4'd0,
    LEN2  = 4'd1,
    LEN4  = 4'd3,
    LEN8  = 4'd7,
    LEN16 = 4'd15
  } cbus_len_t;

  typedef struct packed {
    logic        valid;
    logic        is_write;
    cbus_size_t  size;
    logic [31:0] addr;
    logic [7:0]  strobe;
    logic [63:0] data;
    cbus_len_t   len;
  } cbus_req_t;

  typedef struct packed {
    logic        ready;
    logic        last;
    logic [63:0] data;
  } cbus_resp_t;

  // One bit wider than the largest len so an overrun past LEN16 is still visible.
  localparam int CNT_W = 5;

endpackage

// File: rtl/cbus_rr_arbiter_picker.sv
// Round-robin priority picker (purely combinational).
//   req_i   : request vector, one bit per requester
//   ptr_i   : index of the most recently served requester (lowest priority)
//   found_o : at least one request is pending
//   idx_o   : first requesting index scanning ptr_i+1, ptr_i+2, ... mod NUM_INPUTS
module rr_priority_picker #(
  parameter int NUM_INPUTS = 4,
  parameter int IDX_W      = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1
) (
  input  logic [NUM_INPUTS-1:0] req_i,
  input  logic [IDX_W-1:0]      ptr_i,
  output logic                  found_o,
  output logic [IDX_W-1:0]      idx_o
);

  always_comb begin
    int               cand;
    logic [IDX_W-1:0] cidx;
    found_o = 1'b0;
    idx_o   = '0;
    cand    = 0;
    cidx    = '0;
    for (int k = 1; k <= NUM_INPUTS; k++) begin
      // ptr_i <= NUM_INPUTS-1 and k <= NUM_INPUTS, so one subtraction wraps
      // correctly even when NUM_INPUTS is not a power of two.
      cand = int'(ptr_i) + k;
      if (cand >= NUM_INPUTS) cand = cand - NUM_INPUTS;
      cidx = IDX_W'(cand);
      if (!found_o && req_i[cidx]) begin
        found_o = 1'b1;
        idx_o   = cidx;
      end
    end
  end

endmodule

// File: rtl/cbus_rr_arbiter.sv
// Round-robin arbiter sharing one CBus port between NUM_INPUTS requesters.
// A grant is held for the whole burst; priority rotates after each completed
// transaction, and one IDLE bubble separates back-to-back transactions.
//   clk, reset : clock, synchronous active-high reset
//   ireqs      : per-requester requests
//   iresps     : per-requester responses (only the granted one is non-zero)
//   oreq       : request forwarded to memory (combinational pass-through)
//   oresp      : response from memory
//   busy       : a transaction is granted and in flight
//   grant_idx  : current or most recent grantee
import cbus_rr_arbiter_pkg::*;

module cbus_rr_arbiter #(
  parameter int NUM_INPUTS = 4,
  parameter int IDX_W      = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  cbus_req_t  [NUM_INPUTS-1:0]  ireqs,
  output cbus_resp_t [NUM_INPUTS-1:0]  iresps,
  output cbus_req_t                    oreq,
  input  cbus_resp_t                   oresp,
  output logic                         busy,
  output logic [IDX_W-1:0]             grant_idx
);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] sel_q, sel_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             beat_err_q, beat_err_d;

  logic [NUM_INPUTS-1:0] req_vld;
  logic                  pick_found;
  logic [IDX_W-1:0]      pick_idx;
  logic [CNT_W-1:0]      len_last;

  always_comb begin
    req_vld = '0;
    for (int i = 0; i < NUM_INPUTS; i++) req_vld[i] = ireqs[i].valid;
  end

  rr_priority_picker #(
    .NUM_INPUTS (NUM_INPUTS),
    .IDX_W      (IDX_W)
  ) u_picker (
    .req_i   (req_vld),
    .ptr_i   (ptr_q),
    .found_o (pick_found),
    .idx_o   (pick_idx)
  );

  // Index of the final beat for the granted burst (len is beats-1).
  assign len_last = CNT_W'(ireqs[sel_q].len);

  always_comb begin
    state_d    = state_q;
    sel_d      = sel_q;
    ptr_d      = ptr_q;
    cnt_d      = cnt_q;
    beat_err_d = beat_err_q;
    case (state_q)
      IDLE: begin
        if (pick_found) begin
          sel_d   = pick_idx;
          cnt_d   = '0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (oresp.ready) begin
          if (oresp.last) begin
            if (cnt_q != len_last) beat_err_d = 1'b1;
            state_d = IDLE;
            ptr_d   = sel_q;
          end else begin
            // A non-final beat at or beyond the last index is an overrun.
            if (cnt_q >= len_last) beat_err_d = 1'b1;
            if (cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    oreq   = '0;
    iresps = '0;
    busy   = 1'b0;
    if (state_q == BUSY) begin
      busy          = 1'b1;
      oreq          = ireqs[sel_q];
      iresps[sel_q] = oresp;
    end
  end

  assign grant_idx = sel_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      sel_q      <= '0;
      // Last-served pointer parked at the top so index 0 is scanned first.
      ptr_q      <= IDX_W'(NUM_INPUTS - 1);
      cnt_q      <= '0;
      beat_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      ptr_q      <= ptr_d;
      cnt_q      <= cnt_d;
      beat_err_q <= beat_err_d;
    end
  end

  // Protocol-violation flag is observation-only; it never gates the handshake.
  cover property (@(posedge clk) beat_err_q);

endmodule

// File: tb/tb_cbus_rr_arbiter.sv
import cbus_rr_arbiter_pkg::*;

module tb_cbus_rr_arbiter;

  localparam int N = 4;

  logic                 clk = 1'b0;
  logic                 reset;
  cbus_req_t  [N-1:0]   ireqs;
  cbus_resp_t [N-1:0]   iresps;
  cbus_req_t            oreq;
  cbus_resp_t           oresp;
  logic                 busy;
  logic [1:0]           grant_idx;

  cbus_rr_arbiter #(.NUM_INPUTS(N)) dut (
    .clk       (clk),
    .reset     (reset),
    .ireqs     (ireqs),
    .iresps    (iresps),
    .oreq      (oreq),
    .oresp     (oresp),
    .busy      (busy),
    .grant_idx (grant_idx)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Requester agents
  cbus_req_t rq [N];
  bit        active [N];
  bit        auto_en [N];
  bit        rand_new   = 1'b0;
  bit        rdy_rand   = 1'b0;
  bit        rand_reset = 1'b0;
  int        force_last = -1;

  // Transaction-level reference: who owns the bus, who was served last,
  // how many beats of the current burst have completed.
  int m_owner = -1;
  int m_ptr   = N - 1;
  int m_grant = 0;
  int m_cnt   = 0;
  bit m_err   = 1'b0;
  int glog[$];

  function automatic cbus_len_t rand_len();
    case ($urandom_range(0, 3))
      0:       return LEN1;
      1:       return LEN2;
      2:       return LEN4;
      default: return LEN8;
    endcase
  endfunction

  function automatic cbus_req_t make_req(cbus_len_t l, bit wr);
    cbus_req_t r;
    r.valid    = 1'b1;
    r.is_write = wr;
    r.size     = cbus_size_t'(3'($urandom_range(0, 3)));
    r.addr     = $urandom;
    r.strobe   = wr ? 8'($urandom) : 8'h00;
    r.data     = {$urandom, $urandom};
    r.len      = l;
    return r;
  endfunction

  task automatic chk(string tag, logic [127:0] obs, logic [127:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_inputs();
    if (rand_reset) reset = ($urandom_range(0, 99) == 0);
    for (int i = 0; i < N; i++) begin
      if (!active[i] && rand_new && $urandom_range(0, 3) == 0) begin
        rq[i]     = make_req(rand_len(), 1'($urandom_range(0, 1)));
        active[i] = 1'b1;
      end
      ireqs[i] = active[i] ? rq[i] : '0;
    end
    oresp.data = {$urandom, $urandom};
    if (m_owner >= 0) begin
      oresp.ready = rdy_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
      oresp.last  = oresp.ready &&
                    (m_cnt == ((force_last >= 0) ? force_last : int'(rq[m_owner].len)));
    end else begin
      oresp.ready = 1'b0;
      oresp.last  = 1'b0;
    end
  endtask

  task automatic model_update();
    int served;
    if (reset) begin
      m_owner = -1;
      m_ptr   = N - 1;
      m_grant = 0;
      m_cnt   = 0;
      m_err   = 1'b0;
    end else if (m_owner < 0) begin
      for (int k = 1; k <= N; k++) begin
        int c;
        c = (m_ptr + k) % N;
        if (m_owner < 0 && ireqs[c].valid) begin
          m_owner = c;
          m_grant = c;
          m_cnt   = 0;
          glog.push_back(c);
        end
      end
    end else if (oresp.ready) begin
      if (oresp.last) begin
        if (m_cnt != int'(ireqs[m_owner].len)) m_err = 1'b1;
        served         = m_owner;
        m_ptr          = served;
        m_owner        = -1;
        active[served] = 1'b0;
        if (auto_en[served]) begin
          rq[served] = make_req(rand_new ? rand_len() : rq[served].len, rq[served].is_write);
          active[served] = 1'b1;
        end
      end else begin
        if (m_cnt >= int'(ireqs[m_owner].len)) m_err = 1'b1;
        m_cnt++;
        if (rq[m_owner].is_write) rq[m_owner].data = {$urandom, $urandom};
      end
    end
  endtask

  task automatic check_outputs();
    cbus_req_t  exp_req;
    cbus_resp_t exp_rsp;
    exp_req = (m_owner >= 0) ? ireqs[m_owner] : '0;
    chk("busy", 128'(busy), 128'(m_owner >= 0));
    chk("grant_idx", 128'(grant_idx), 128'(m_grant));
    chk("oreq", 128'(oreq), 128'(exp_req));
    for (int j = 0; j < N; j++) begin
      exp_rsp = (j == m_owner) ? oresp : '0;
      chk($sformatf("iresps[%0d]", j), 128'(iresps[j]), 128'(exp_rsp));
    end
    chk("beat_err", 128'(dut.beat_err_q), 128'(m_err));
  endtask

  task automatic cyc();
    @(posedge clk);
    model_update();
    #1;
    drive_inputs();
    #1;
    check_outputs();
  endtask

  task automatic run(int n);
    for (int t = 0; t < n; t++) cyc();
  endtask

  task automatic reset_all();
    for (int i = 0; i < N; i++) begin
      active[i]  = 1'b0;
      auto_en[i] = 1'b0;
    end
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    glog.delete();
  endtask

  task automatic chk_grant(string tag, int k, int exp);
    int g;
    g = (k < glog.size()) ? glog[k] : -1;
    chk($sformatf("%s grant[%0d]", tag, k), 128'(g), 128'(exp));
  endtask

  initial begin
    reset = 1'b1;
    ireqs = '0;
    oresp = '0;
    for (int i = 0; i < N; i++) begin
      active[i]  = 1'b0;
      auto_en[i] = 1'b0;
      rq[i]      = '0;
    end

    // Reset state
    run(2);
    chk("reset ptr", 128'(dut.ptr_q), 128'(N - 1));
    reset = 1'b0;
    glog.delete();

    // Single LEN4 read from requester 2
    rq[2]     = make_req(LEN4, 1'b0);
    active[2] = 1'b1;
    run(9);
    chk("single ngrants", 128'(glog.size()), 128'(1));
    chk_grant("single", 0, 2);
    chk("single ptr", 128'(dut.ptr_q), 128'(2));
    chk("single idle", 128'(busy), 128'(0));

    // All four simultaneously
    reset_all();
    for (int i = 0; i < N; i++) begin
      rq[i]     = make_req(LEN1, 1'b0);
      active[i] = 1'b1;
    end
    run(12);
    chk("all4 ngrants", 128'(glog.size()), 128'(4));
    for (int k = 0; k < 4; k++) chk_grant("all4", k, k);

    // Fairness: 0 and 3 always requesting, LEN1
    reset_all();
    rq[0] = make_req(LEN1, 1'b0); active[0] = 1'b1; auto_en[0] = 1'b1;
    rq[3] = make_req(LEN1, 1'b0); active[3] = 1'b1; auto_en[3] = 1'b1;
    run(16);
    for (int k = 0; k < 6; k++) chk_grant("fair", k, (k % 2 == 0) ? 0 : 3);

    // Write burst from requester 1, data changing every beat
    reset_all();
    rq[1]     = make_req(LEN2, 1'b1);
    active[1] = 1'b1;
    run(6);
    chk_grant("write", 0, 1);

    // Reset on beat 2 of a LEN4 read from requester 1
    reset_all();
    rq[1]     = make_req(LEN4, 1'b0);
    active[1] = 1'b1;
    for (int t = 0; t < 10 && !(m_owner == 1 && m_cnt == 1); t++) cyc();
    chk("midrst busy before", 128'(busy), 128'(1));
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    chk("midrst busy", 128'(busy), 128'(0));
    chk("midrst grant_idx", 128'(grant_idx), 128'(0));
    chk("midrst oreq.valid", 128'(oreq.valid), 128'(0));
    glog.delete();
    rq[1] = make_req(LEN1, 1'b0); active[1] = 1'b1;
    rq[3] = make_req(LEN1, 1'b0); active[3] = 1'b1;
    run(8);
    chk_grant("midrst", 0, 1);
    chk_grant("midrst", 1, 3);

    // Early last on beat 3 of a LEN4 burst
    reset_all();
    force_last = 2;
    rq[0]      = make_req(LEN4, 1'b0);
    active[0]  = 1'b1;
    run(8);
    force_last = -1;
    chk("proto beat_err", 128'(dut.beat_err_q), 128'(1));
    chk("proto idle", 128'(busy), 128'(0));

    // Randomized traffic with random ready stalls and occasional resets
    reset_all();
    rdy_rand   = 1'b1;
    rand_new   = 1'b1;
    rand_reset = 1'b1;
    for (int i = 0; i < N; i++) auto_en[i] = 1'($urandom_range(0, 1));
    run(600);
    rand_reset = 1'b0;
    reset      = 1'b0;
    rand_new   = 1'b0;
    for (int i = 0; i < N; i++) auto_en[i] = 1'b0;
    for (int t = 0; t < 300 && (m_owner >= 0 || active[0] || active[1] || active[2] || active[3]); t++)
      cyc();
    run(2);
    chk("drain idle", 128'(busy), 128'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cbus_rr_arbiter.md
Name: cbus_rr_arbiter

Overview:
- Round-robin arbiter sharing the single uncached/cache-refill CBus port between NUM_INPUTS requesters (I-cache and D-cache refill/writeback channels).
- Sits between the cache layer (icreq/dcreq arrays) and the top-level oreq/oresp.
- Grants one requester per transaction and holds the grant for the whole burst until the final beat.
- Rotates priority after each completed transaction so no requester starves.

Parameters:
- NUM_INPUTS, 4, number of requesters; index 0 has highest priority after reset.
- IDX_W, $clog2(NUM_INPUTS), width of the grant index (derived; do not override).

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- ireqs  input  cbus_req_t[NUM_INPUTS]  per-requester CBus requests (valid, is_write, size, addr, strobe, data, len)
- iresps  output  cbus_resp_t[NUM_INPUTS]  per-requester responses (ready, last, data)
- oreq  output  cbus_req_t  request to memory side
- oresp  input  cbus_resp_t  response from memory side
- busy  output  1  a transaction is granted and in flight
- grant_idx  output  IDX_W  index of the current or last granter (debug/perf)

Behaviour:
- Reset: one clock, synchronous, active-high. On reset:
  - state=IDLE, busy=0, grant_idx=0.
  - Priority pointer ptr = NUM_INPUTS-1, so index 0 is checked first.
  - oreq is all zero and every iresps[i] is all zero.
- State IDLE:
  - oreq.valid=0 and all iresps are zero.
  - Pick the first i with ireqs[i].valid=1, scanning (ptr+1), (ptr+2), ... mod NUM_INPUTS.
  - If a requester is found: register sel=i, grant_idx=i, go to BUSY next cycle.
  - If none: stay in IDLE.
- State BUSY:
  - oreq = ireqs[sel], passed through combinationally, so write data and strobe track the requester's beats.
  - iresps[sel] = oresp; iresps[j]=0 for every j≠sel. busy=1.
- Beat counter:
  - cnt counts oresp.ready beats, starting at 0 on grant.
  - beat_err is an internal assertion flag. It is set when oresp.last arrives with cnt≠ireqs[sel].len, or when cnt exceeds len. Simulation-only check; no effect on the handshake.
- Transaction end: on a cycle with oresp.ready=1 and oresp.last=1, the next state is IDLE and ptr=sel.
- Latency and bubbles:
  - oreq.valid rises exactly 1 cycle after the first cycle an IDLE arbiter sees a valid request.
  - There is exactly one IDLE bubble cycle between back-to-back transactions.
  - Re-arbitration happens in that bubble, with the just-served requester at lowest priority.
- Protocol rules:
  - A requester must hold valid and its fields stable until it sees ready&&last.
  - If the granted requester drops valid mid-burst, the arbiter stays in BUSY. It forwards oreq.valid=0 and waits for last. Requests are never aborted.
- Simultaneous events:
  - A requester asserting valid during the end-of-transaction cycle is eligible in the following IDLE cycle.
  - Requests arriving during BUSY are only sampled in IDLE.
- Single requester: it is re-granted after every one-cycle bubble.
- Reset mid-burst: the arbiter drops to IDLE immediately and forces all outputs to zero. Downstream memory is reset by the same signal.
- Widths: ptr and sel are IDX_W wide. Wrap-around is modulo NUM_INPUTS. Handle non-power-of-two NUM_INPUTS explicitly, never by bit truncation.

Decomposition:
- cbus_req_t, cbus_resp_t and the cbus len/size enums remain in the shared common package; the arbiter adds no new typedefs there.
- A local typedef for the state enum (IDLE, BUSY) lives inside the module.
- One combinational sub-module, rr_priority_picker:
  - Inputs: req vector [NUM_INPUTS], ptr.
  - Outputs: found, idx.
  - Reused by any future N-way arbiter.

Test Plan:
- Single request: reset, then ireqs[2].valid with len=LEN4 → oreq.valid rises 1 cycle later with addr=ireqs[2].addr; 4 ready beats forwarded to iresps[2] only; IDLE after last; ptr=2.
- All four request simultaneously after reset → grant order 0,1,2,3, each followed by a 1-cycle bubble; grant_idx sequence 0,1,2,3.
- Fairness: requesters 0 and 3 always valid, each with len=LEN1 → grants alternate 0,3,0,3; neither is granted twice in a row while the other waits.
- Write burst: ireqs[1].is_write=1, len=LEN2, data changing per beat → oreq.data follows ireqs[1].data on each ready beat; iresps[0],[2],[3] stay 0 throughout.
- Reset mid-burst: assert reset on beat 2 of a LEN4 read from requester 1 → next cycle oreq.valid=0, busy=0, grant_idx=0; a new request from 3 is then granted before 1 if 1 re-requests at the same time (index 3 precedes 1? no, 0-first scan: 1 before 3). Check that 1 wins.
- Protocol check: oresp.last on beat 3 of a LEN4 burst → beat_err asserts and the arbiter still returns to IDLE.
